// File: rtl/nvm_access_arbiter.sv
// Two-requester arbiter and sequencer for the 256x8 embedded NVM macro wrapper.
// Round-robin grant, one operation in flight, per-transaction timeout,
// reserved opcodes answered with an error and never forwarded to the macro.
module nvm_access_arbiter #(
   parameter int unsigned NBW_DATA   = 8,
   parameter int unsigned NBW_TMO    = 8,
   parameter int unsigned TMO_CYCLES = 200,
   parameter logic [3:0]  OP_RSVD    = 4'hF
) (
   input  logic                clk,
   input  logic                rst_sync,
   input  logic                i_req0_valid,
   output logic                o_req0_ready,
   input  logic [NBW_DATA-1:0] i_req0_addr,
   input  logic [NBW_DATA-1:0] i_req0_data,
   input  logic [3:0]          i_req0_op,
   input  logic                i_req0_region,
   input  logic                i_req1_valid,
   output logic                o_req1_ready,
   input  logic [NBW_DATA-1:0] i_req1_addr,
   input  logic [NBW_DATA-1:0] i_req1_data,
   input  logic [3:0]          i_req1_op,
   input  logic                i_req1_region,
   output logic                o_rsp0_valid,
   output logic [NBW_DATA-1:0] o_rsp0_data,
   output logic                o_rsp0_err,
   output logic                o_rsp1_valid,
   output logic [NBW_DATA-1:0] o_rsp1_data,
   output logic                o_rsp1_err,
   output logic [NBW_DATA-1:0] o_mem_addr,
   output logic [NBW_DATA-1:0] o_mem_data,
   output logic [3:0]          o_mem_op,
   output logic                o_mem_region,
   output logic                o_mem_op_valid,
   input  logic [NBW_DATA-1:0] i_mem_data,
   input  logic                i_mem_valid,
   output logic                o_busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t              state, state_next;
   logic                last_grant;   // 1: req1 won last, so req0 is favoured
   logic                owner;
   logic [NBW_TMO-1:0]  tmo_cnt;
   logic                tmo_hit;

   logic                grant0, grant1, accept, sel_rsvd;
   logic [NBW_DATA-1:0] sel_addr, sel_data;
   logic [3:0]          sel_op;
   logic                sel_region;
   logic                rsp_fire, rsp_owner, rsp_err_c;
   logic [NBW_DATA-1:0] rsp_data_c;

   assign tmo_hit = (tmo_cnt == NBW_TMO'(TMO_CYCLES - 1));

   // Grant selection, next-state and response decision
   always_comb begin
      state_next = state;
      grant0     = 1'b0;
      grant1     = 1'b0;
      accept     = 1'b0;
      sel_addr   = grant1 ? i_req1_addr : i_req0_addr;
      sel_addr   = i_req1_valid & ~grant0 ? i_req1_addr : i_req0_addr;
      sel_data   = '0;
      sel_op     = '0;
      sel_region = 1'b0;
      sel_rsvd   = 1'b0;
      rsp_fire   = 1'b0;
      rsp_owner  = owner;
      rsp_data_c = '0;
      rsp_err_c  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            grant0     = i_req0_valid & (~i_req1_valid | last_grant);
            grant1     = i_req1_valid & (~i_req0_valid | ~last_grant);
            accept     = grant0 | grant1;
            sel_addr   = grant1 ? i_req1_addr   : i_req0_addr;
            sel_data   = grant1 ? i_req1_data   : i_req0_data;
            sel_op     = grant1 ? i_req1_op     : i_req0_op;
            sel_region = grant1 ? i_req1_region : i_req0_region;
            sel_rsvd   = (sel_op == OP_RSVD);
            if (accept) begin
               if (sel_rsvd) begin
                  state_next = ST_RESP;
                  rsp_fire   = 1'b1;
                  rsp_owner  = grant1;
                  rsp_err_c  = 1'b1;
               end else begin
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT: begin
            // completion takes priority over a coincident timeout
            if (i_mem_valid) begin
               state_next = ST_RESP;
               rsp_fire   = 1'b1;
               rsp_data_c = i_mem_data;
            end else if (tmo_hit) begin
               state_next = ST_RESP;
               rsp_fire   = 1'b1;
               rsp_err_c  = 1'b1;
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      o_req0_ready = grant0;
      o_req1_ready = grant1;
      o_busy       = (state != ST_IDLE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst_sync) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Request capture, timeout counter and registered response strobes
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         tmo_cnt        <= '0;
         o_mem_addr     <= '0;
         o_mem_data     <= '0;
         o_mem_op       <= '0;
         o_mem_region   <= 1'b0;
         o_mem_op_valid <= 1'b0;
         o_rsp0_valid   <= 1'b0;
         o_rsp0_data    <= '0;
         o_rsp0_err     <= 1'b0;
         o_rsp1_valid   <= 1'b0;
         o_rsp1_data    <= '0;
         o_rsp1_err     <= 1'b0;
      end else begin
         o_mem_op_valid <= accept & ~sel_rsvd;
         if (accept) begin
            owner      <= grant1;
            last_grant <= grant1;
            if (!sel_rsvd) begin
               o_mem_addr   <= sel_addr;
               o_mem_data   <= sel_data;
               o_mem_op     <= sel_op;
               o_mem_region <= sel_region;
            end
         end
         if (state == ST_ISSUE)
            tmo_cnt <= '0;
         else if (state == ST_WAIT && !i_mem_valid && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
         o_rsp0_valid <= rsp_fire & ~rsp_owner;
         o_rsp0_data  <= (rsp_fire & ~rsp_owner) ? rsp_data_c : '0;
         o_rsp0_err   <= rsp_fire & ~rsp_owner & rsp_err_c;
         o_rsp1_valid <= rsp_fire & rsp_owner;
         o_rsp1_data  <= (rsp_fire & rsp_owner) ? rsp_data_c : '0;
         o_rsp1_err   <= rsp_fire & rsp_owner & rsp_err_c;
      end
   end

endmodule
